cvxif_copro_responder: RTL and testbench

Coprocessor-side responder for the CV-X-IF port the core drives when `CvxifEn` is set. It decodes custom-0 instructions offered on the issue channel and accepts or rejects them. Accepted instructions are tracked in a small in-order table, which collects operands from the register channel and commit/kill decisions from the commit channel. Results are returned to the core's writeback on the result channel. It sits beside the core in place of the example coprocessor.

---
 rtl/cvxif_copro_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-0 ALU ops, tracks them in order, returns results.
// Defining CVXIF_COPRO_MUL_EN adds a two-cycle pipelined multiply on funct3=4.
module cvxif_copro_responder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned NrEntries = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               register_valid_i,
  input  logic [IdWidth-1:0] register_id_i,
  input  logic [XLEN-1:0]    register_rs1_i,
  input  logic [XLEN-1:0]    register_rs2_i,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic [XLEN-1:0]    result_data_o
);

  localparam int unsigned PtrW = $clog2(NrEntries);
  localparam int unsigned CntW = PtrW + 1;

  logic [2:0] dec_funct3;
  logic [4:0] dec_rd;
  logic       dec_funct_ok;
  logic       unused_instr_bits;

  assign dec_funct3 = issue_instr_i[14:12];
  assign dec_rd     = issue_instr_i[11:7];
  // Register specifiers are irrelevant here: operand values arrive on the register channel.
  assign unused_instr_bits = ^issue_instr_i[24:15];

  always_comb begin
    case (dec_funct3)
      3'd0, 3'd1, 3'd2, 3'd3: dec_funct_ok = 1'b1;
`ifdef CVXIF_COPRO_MUL_EN
      3'd4:                   dec_funct_ok = 1'b1;
`endif
      default:                dec_funct_ok = 1'b0;
    endcase
  end

  assign issue_accept_o    = (issue_instr_i[6:0] == 7'h0B) && (issue_instr_i[31:25] == 7'd0) &&
                             dec_funct_ok;
  assign issue_writeback_o = issue_accept_o && (dec_rd != 5'd0);

  // Outstanding-instruction table
  logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [NrEntries-1:0] valid_q, valid_d, ops_q, ops_d, commit_q, commit_d;
  logic [NrEntries-1:0] kill_q, kill_d, we_q, we_d;
  logic [IdWidth-1:0]   id_q     [NrEntries];
  logic [IdWidth-1:0]   id_d     [NrEntries];
  logic [2:0]           funct3_q [NrEntries];
  logic [2:0]           funct3_d [NrEntries];
  logic [4:0]           rd_q     [NrEntries];
  logic [4:0]           rd_d     [NrEntries];
  logic [XLEN-1:0]      rs1_q    [NrEntries];
  logic [XLEN-1:0]      rs1_d    [NrEntries];
  logic [XLEN-1:0]      rs2_q    [NrEntries];
  logic [XLEN-1:0]      rs2_d    [NrEntries];

  logic               result_valid_q, result_valid_d, result_we_q, result_we_d;
  logic [IdWidth-1:0] result_id_q, result_id_d;
  logic [4:0]         result_rd_q, result_rd_d;
  logic [XLEN-1:0]    result_data_q, result_data_d;

  logic            full, push, pop, pop_kill, pop_done, mul_load, res_free;
  logic            head_valid, head_ready, head_is_mul, mul_busy;
  logic [2:0]      head_funct3;
  logic [XLEN-1:0] head_rs1, head_rs2, alu_res;

  assign full          = (count_q == CntW'(NrEntries));
  assign issue_ready_o = !full && !rst_i;
  assign push          = issue_valid_i && issue_ready_o && issue_accept_o;

  assign head_valid  = valid_q[head_q];
  assign head_ready  = head_valid && !kill_q[head_q] && ops_q[head_q] && commit_q[head_q];
  assign head_funct3 = funct3_q[head_q];
  assign head_rs1    = rs1_q[head_q];
  assign head_rs2    = rs2_q[head_q];
  assign res_free    = !result_valid_q || result_ready_i;

  // Killed entries retire without needing the result register.
  assign pop_kill = head_valid && kill_q[head_q];
  assign pop_done = head_ready && !head_is_mul && !mul_busy && res_free;
  assign mul_load = head_ready && head_is_mul && !mul_busy;
  assign pop      = pop_kill || pop_done || mul_load;

  always_comb begin
    case (head_funct3)
      3'd0:    alu_res = head_rs1 + head_rs2;
      3'd1:    alu_res = head_rs1 ^ head_rs2;
      3'd2:    alu_res = head_rs1 - head_rs2;
      3'd3:    alu_res = head_rs1 & head_rs2;
      default: alu_res = '0;
    endcase
  end

`ifdef CVXIF_COPRO_MUL_EN
  logic               mul_valid_q, mul_valid_d, mul_we_q, mul_we_d;
  logic [IdWidth-1:0] mul_id_q, mul_id_d;
  logic [4:0]         mul_rd_q, mul_rd_d;
  logic [XLEN-1:0]    mul_data_q, mul_data_d;

  assign head_is_mul = (head_funct3 == 3'd4);
  // Younger heads stall while a product is in flight to keep results in order.
  assign mul_busy    = mul_valid_q;

  always_comb begin
    mul_valid_d = mul_valid_q && !res_free;
    mul_id_d    = mul_id_q;
    mul_rd_d    = mul_rd_q;
    mul_we_d    = mul_we_q;
    mul_data_d  = mul_data_q;
    if (mul_load) begin
      mul_valid_d = 1'b1;
      mul_id_d    = id_q[head_q];
      mul_rd_d    = rd_q[head_q];
      mul_we_d    = we_q[head_q];
      mul_data_d  = head_rs1 * head_rs2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_valid_q <= 1'b0;
      mul_id_q    <= '0;
      mul_rd_q    <= '0;
      mul_we_q    <= 1'b0;
      mul_data_q  <= '0;
    end else begin
      mul_valid_q <= mul_valid_d;
      mul_id_q    <= mul_id_d;
      mul_rd_q    <= mul_rd_d;
      mul_we_q    <= mul_we_d;
      mul_data_q  <= mul_data_d;
    end
  end
`else
  assign head_is_mul = 1'b0;
  assign mul_busy    = 1'b0;
`endif

  always_comb begin
    result_valid_d = result_valid_q && !result_ready_i;
    result_id_d    = result_id_q;
    result_rd_d    = result_rd_q;
    result_we_d    = result_we_q;
    result_data_d  = result_data_q;
    if (pop_done) begin
      result_valid_d = 1'b1;
      result_id_d    = id_q[head_q];
      result_rd_d    = rd_q[head_q];
      result_we_d    = we_q[head_q];
      result_data_d  = alu_res;
    end
`ifdef CVXIF_COPRO_MUL_EN
    if (mul_valid_q && res_free) begin
      result_valid_d = 1'b1;
      result_id_d    = mul_id_q;
      result_rd_d    = mul_rd_q;
      result_we_d    = mul_we_q;
      result_data_d  = mul_data_q;
    end
`endif
  end

  always_comb begin
    valid_d  = valid_q;
    ops_d    = ops_q;
    commit_d = commit_q;
    kill_d   = kill_q;
    we_d     = we_q;
    id_d     = id_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    head_d   = pop ? head_q + PtrW'(1) : head_q;
    tail_d   = push ? tail_q + PtrW'(1) : tail_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    // The slot being issued is not yet valid, so same-cycle register/commit cannot hit it.
    for (int i = 0; i < NrEntries; i++) begin
      if (register_valid_i && valid_q[i] && !ops_q[i] && (id_q[i] == register_id_i)) begin
        ops_d[i] = 1'b1;
        rs1_d[i] = register_rs1_i;
        rs2_d[i] = register_rs2_i;
      end
      if (commit_valid_i && valid_q[i] && (id_q[i] == commit_id_i)) begin
        if (commit_kill_i) kill_d[i] = 1'b1;
        else               commit_d[i] = 1'b1;
      end
    end
    if (pop) valid_d[head_q] = 1'b0;
    if (push) begin
      valid_d[tail_q]  = 1'b1;
      ops_d[tail_q]    = 1'b0;
      commit_d[tail_q] = 1'b0;
      kill_d[tail_q]   = 1'b0;
      we_d[tail_q]     = issue_writeback_o;
      id_d[tail_q]     = issue_id_i;
      funct3_d[tail_q] = dec_funct3;
      rd_d[tail_q]     = dec_rd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      ops_q          <= '0;
      commit_q       <= '0;
      kill_q         <= '0;
      we_q           <= '0;
      id_q           <= '{default: '0};
      funct3_q       <= '{default: '0};
      rd_q           <= '{default: '0};
      rs1_q          <= '{default: '0};
      rs2_q          <= '{default: '0};
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_rd_q    <= '0;
      result_we_q    <= 1'b0;
      result_data_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ops_q          <= ops_d;
      commit_q       <= commit_d;
      kill_q         <= kill_d;
      we_q           <= we_d;
      id_q           <= id_d;
      funct3_q       <= funct3_d;
      rd_q           <= rd_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_rd_q    <= result_rd_d;
      result_we_q    <= result_we_d;
      result_data_q  <= result_data_d;
    end
  end

  assign result_valid_o = result_valid_q;
  assign result_id_o    = result_id_q;
  assign result_rd_o    = result_rd_q;
  assign result_we_o    = result_we_q;
  assign result_data_o  = result_data_q;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed bench for cvxif_copro_responder with a result scoreboard (default build, no multiply).
module tb_cvxif_copro_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_id_i, register_id_i, commit_id_i, result_id_o;
  logic        register_valid_i, commit_valid_i, commit_kill_i;
  logic [31:0] register_rs1_i, register_rs2_i, result_data_o;
  logic        result_valid_o, result_ready_i, result_we_o;
  logic [4:0]  result_rd_o;

  typedef struct packed {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  cvxif_copro_responder #(.XLEN(32), .IdWidth(3), .NrEntries(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .register_valid_i  (register_valid_i),
    .register_id_i     (register_id_i),
    .register_rs1_i    (register_rs1_i),
    .register_rs2_i    (register_rs2_i),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o),
    .result_data_o     (result_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a ^ b;
      3'd2:    return a - b;
      default: return a & b;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_issue(input string tag, input logic [31:0] instr, input logic [2:0] id,
                          input logic exp_acc, input logic exp_wb);
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_id_i    = id;
    #1;
    check({tag, "_accept"}, 64'(issue_accept_o), 64'(exp_acc));
    check({tag, "_wb"}, 64'(issue_writeback_o), 64'(exp_wb));
    cyc();
    issue_valid_i = 1'b0;
  endtask

  task automatic drive_regs(input logic [2:0] id, input logic [31:0] a, input logic [31:0] b);
    register_valid_i = 1'b1;
    register_id_i    = id;
    register_rs1_i   = a;
    register_rs2_i   = b;
    cyc();
    register_valid_i = 1'b0;
  endtask

  task automatic drive_commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    cyc();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  // Operands and commit in one cycle; optionally queues the expected result.
  task automatic ops_commit(input logic [2:0] id, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic expect_res);
    if (expect_res) sb.push_back('{id: id, rd: rd, we: (rd != 5'd0), data: model(f3, a, b)});
    register_valid_i = 1'b1;
    register_id_i    = id;
    register_rs1_i   = a;
    register_rs2_i   = b;
    commit_valid_i   = 1'b1;
    commit_id_i      = id;
    commit_kill_i    = 1'b0;
    cyc();
    register_valid_i = 1'b0;
    commit_valid_i   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Result monitor: every completed result transfer is checked against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && result_valid_o && result_ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_result", 64'(result_valid_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_id", 64'(result_id_o), 64'(e.id));
        check("res_rd", 64'(result_rd_o), 64'(e.rd));
        check("res_we", 64'(result_we_o), 64'(e.we));
        check("res_data", 64'(result_data_o), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0;
    register_valid_i = 1'b0; register_id_i = '0; register_rs1_i = '0; register_rs2_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    result_ready_i = 1'b1;

    // Reset state
    cyc(); cyc();
    #1;
    check("rst_ready", 64'(issue_ready_o), 64'd0);
    check("rst_valid", 64'(result_valid_o), 64'd0);
    check("rst_id", 64'(result_id_o), 64'd0);
    check("rst_rd", 64'(result_rd_o), 64'd0);
    check("rst_we", 64'(result_we_o), 64'd0);
    check("rst_data", 64'(result_data_o), 64'd0);
    cyc();
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(issue_ready_o), 64'd1);

    // Basic add with latency check
    do_issue("add", enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd1, 7'h0B), 3'd2, 1'b1, 1'b1);
    drive_regs(3'd2, 32'd5, 32'd7);
    sb.push_back('{id: 3'd2, rd: 5'd1, we: 1'b1, data: 32'd12});
    drive_commit(3'd2, 1'b0);
    #1;
    check("lat_not_yet", 64'(result_valid_o), 64'd0);
    cyc();
    #1;
    check("lat_valid", 64'(result_valid_o), 64'd1);
    wait_drain("drain_add");

    // Rejects
    do_issue("rej_op33", enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd1, 7'h33), 3'd0, 1'b0, 1'b0);
    do_issue("rej_f7", enc(7'd1, 5'd2, 5'd1, 3'd0, 5'd1, 7'h0B), 3'd0, 1'b0, 1'b0);
    do_issue("rej_f3_5", enc(7'd0, 5'd2, 5'd1, 3'd5, 5'd1, 7'h0B), 3'd0, 1'b0, 1'b0);
`ifndef CVXIF_COPRO_MUL_EN
    do_issue("rej_mul", enc(7'd0, 5'd2, 5'd1, 3'd4, 5'd1, 7'h0B), 3'd0, 1'b0, 1'b0);
`endif

    // Fill the table; rejects above must not have allocated
    do_issue("fill0", enc(7'd0, 5'd2, 5'd1, 3'd1, 5'd4, 7'h0B), 3'd0, 1'b1, 1'b1);
    do_issue("fill1", enc(7'd0, 5'd2, 5'd1, 3'd3, 5'd5, 7'h0B), 3'd1, 1'b1, 1'b1);
    do_issue("fill2", enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd6, 7'h0B), 3'd2, 1'b1, 1'b1);
    #1;
    check("ready_3_of_4", 64'(issue_ready_o), 64'd1);
    do_issue("fill3", enc(7'd0, 5'd2, 5'd1, 3'd2, 5'd7, 7'h0B), 3'd3, 1'b1, 1'b1);
    #1;
    check("full_ready", 64'(issue_ready_o), 64'd0);
    ops_commit(3'd0, 5'd4, 3'd1, 32'hF0F0_1234, 32'h0FF0_4321, 1'b1);
    #1;
    check("full_pop_cycle_ready", 64'(issue_ready_o), 64'd0);
    cyc();
    #1;
    check("after_pop_ready", 64'(issue_ready_o), 64'd1);
    ops_commit(3'd1, 5'd5, 3'd3, 32'hDEAD_BEEF, 32'h0000_FFFF, 1'b1);
    ops_commit(3'd2, 5'd6, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    ops_commit(3'd3, 5'd7, 3'd2, 32'd100, 32'd58, 1'b1);
    wait_drain("drain_fill");

    // Kill of a non-head entry
    do_issue("k0", enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd8, 7'h0B), 3'd0, 1'b1, 1'b1);
    do_issue("k1", enc(7'd0, 5'd2, 5'd1, 3'd1, 5'd9, 7'h0B), 3'd1, 1'b1, 1'b1);
    do_issue("k2", enc(7'd0, 5'd2, 5'd1, 3'd3, 5'd10, 7'h0B), 3'd2, 1'b1, 1'b1);
    drive_commit(3'd1, 1'b1);
    ops_commit(3'd2, 5'd10, 3'd3, 32'h1234_5678, 32'hFF00_FF00, 1'b1);
    ops_commit(3'd0, 5'd8, 3'd0, 32'd1000, 32'd24, 1'b0);
    sb.push_front('{id: 3'd0, rd: 5'd8, we: 1'b1, data: 32'd1024});
    wait_drain("drain_kill");
    repeat (4) cyc();
    check("kill_empty_ready", 64'(issue_ready_o), 64'd1);

    // sub wrap with rd=0
    do_issue("sub_rd0", enc(7'd0, 5'd2, 5'd1, 3'd2, 5'd0, 7'h0B), 3'd3, 1'b1, 1'b0);
    ops_commit(3'd3, 5'd0, 3'd2, 32'd0, 32'd1, 1'b1);
    wait_drain("drain_sub");

    // Backpressure: result held stable, then reset mid-stream
    result_ready_i = 1'b0;
    do_issue("stall_a", enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h0B), 3'd5, 1'b1, 1'b1);
    do_issue("stall_b", enc(7'd0, 5'd2, 5'd1, 3'd1, 5'd4, 7'h0B), 3'd6, 1'b1, 1'b1);
    ops_commit(3'd5, 5'd3, 3'd0, 32'd10, 32'd20, 1'b0);
    ops_commit(3'd6, 5'd4, 3'd1, 32'd1, 32'd3, 1'b0);
    for (int i = 0; i < 10 && !result_valid_o; i++) cyc();
    check("stall_valid", 64'(result_valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_valid_hold", 64'(result_valid_o), 64'd1);
      check("stall_id_hold", 64'(result_id_o), 64'd5);
      check("stall_rd_hold", 64'(result_rd_o), 64'd3);
      check("stall_we_hold", 64'(result_we_o), 64'd1);
      check("stall_data_hold", 64'(result_data_o), 64'd30);
    end
    rst_i = 1'b1;
    #1;
    check("midrst_ready", 64'(issue_ready_o), 64'd0);
    cyc();
    #1;
    check("midrst_valid", 64'(result_valid_o), 64'd0);
    check("midrst_data", 64'(result_data_o), 64'd0);
    check("midrst_ready_hold", 64'(issue_ready_o), 64'd0);
    cyc();
    rst_i = 1'b0;
    result_ready_i = 1'b1;
    #1;
    check("post_midrst_ready", 64'(issue_ready_o), 64'd1);
    repeat (5) cyc();
    check("post_midrst_no_result", 64'(result_valid_o), 64'd0);

    // Table must be empty: exactly four fresh entries fit
    do_issue("r0", enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd11, 7'h0B), 3'd0, 1'b1, 1'b1);
    do_issue("r1", enc(7'd0, 5'd2, 5'd1, 3'd1, 5'd12, 7'h0B), 3'd1, 1'b1, 1'b1);
    do_issue("r2", enc(7'd0, 5'd2, 5'd1, 3'd2, 5'd13, 7'h0B), 3'd2, 1'b1, 1'b1);
    #1;
    check("post_rst_3_ready", 64'(issue_ready_o), 64'd1);
    do_issue("r3", enc(7'd0, 5'd2, 5'd1, 3'd3, 5'd14, 7'h0B), 3'd3, 1'b1, 1'b1);
    #1;
    check("post_rst_full", 64'(issue_ready_o), 64'd0);
    ops_commit(3'd0, 5'd11, 3'd0, 32'h8000_0000, 32'h8000_0001, 1'b1);
    ops_commit(3'd1, 5'd12, 3'd1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    ops_commit(3'd2, 5'd13, 3'd2, 32'd7, 32'd9, 1'b1);
    ops_commit(3'd3, 5'd14, 3'd3, 32'hCAFE_F00D, 32'h0F0F_0F0F, 1'b1);
    wait_drain("drain_final");
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
